fixed_decoder: RTL
==================

FIXED_DECODER -- requirements
Module: fixed_decoder

Interface
REQ-001 Parameter list: none; widths fixed (16-bit samples, 16-bit block size).
REQ-002 iClock  in  1  system clock; all state changes on rising edge.
REQ-003 iReset  in  1  reset, synchronous, active-high.
REQ-004 iEnable  in  1  clock enable; low = all state and outputs held, iStart and iValid ignored.
REQ-005 iStart  in  1  one-cycle pulse; latches iOrder and iNSamples, begins a subframe.
REQ-006 iOrder  in  3  fixed predictor order, legal 0..4.
REQ-007 iNSamples  in  16  subframe block size (total output samples).
REQ-008 iSample  in  16 signed  warm-up sample or residual, from the residual decoder output.
REQ-009 iValid  in  1  one-cycle strobe qualifying iSample (driven by residual decoder oDone).
REQ-010 oSample  out  16 signed  reconstructed PCM sample.
REQ-011 oValid  out  1  one-cycle strobe qualifying oSample.
REQ-012 oDone  out  1  one-cycle pulse, subframe complete.
REQ-013 oError  out  1  sticky until next iStart or reset; illegal order seen.

Function
REQ-014 States: S_IDLE, S_WARMUP, S_RESIDUAL, S_DONE; encoding free.
REQ-015 S_IDLE: iValid ignored; iStart -> latch order/count, clear history, clear out count, clear oError; next state S_WARMUP if order>0, S_RESIDUAL if order=0.
REQ-016 iStart with iOrder 5..7 -> oError=1, no samples emitted, oDone pulse next cycle, return S_IDLE.
REQ-017 iStart with iNSamples=0 -> S_DONE directly; oDone pulses next cycle; no oValid.
REQ-018 S_WARMUP: each iValid passes iSample to oSample unchanged and pushes it into history; after order warm-ups -> S_RESIDUAL.
REQ-019 S_RESIDUAL: each iValid emits oSample = residual + prediction, pushes result into history.
REQ-020 Prediction from history s1 (newest)..s4: order0 0; order1 s1; order2 2s1-s2; order3 3s1-3s2+s3; order4 4s1-6s2+4s3-s4.
REQ-021 Internal sum width 21 bits signed; no intermediate overflow; default output = low 16 bits (two's-complement wrap).
REQ-022 Latency exactly 1 cycle: oValid asserted the cycle after the accepted iValid; oSample held stable until next oValid.
REQ-023 Output count counts every emitted sample (warm-up and residual); when it reaches latched N -> S_DONE, including when N < order (stays in warm-up).
REQ-024 S_DONE: oDone=1 for one cycle, then S_IDLE; iValid in S_DONE ignored.
REQ-025 iStart while S_WARMUP/S_RESIDUAL aborts: no oDone for aborted subframe, restart per REQ-015 same cycle.
REQ-026 iStart and iValid same cycle: iStart wins, iValid dropped.
REQ-027 iEnable low while iValid high: sample lost; no output that cycle.
REQ-028 Back-to-back iValid every cycle accepted at full rate.

Reset
REQ-029 iReset takes priority over iEnable; state S_IDLE.
REQ-030 Reset values: oSample=0, oValid=0, oDone=0, oError=0, history s1..s4=0, counters 0, latched order/N 0.
REQ-031 Reset mid-subframe discards all history; no oDone emitted.

Configuration
REQ-032 Macro FIXED_DECODER_SATURATE_EN.
REQ-033 Defined: result clamped to [-32768, 32767] before output and before history push.
REQ-034 Undefined: result wraps per REQ-021; no clamp logic synthesised.

Verification
REQ-035 Order 2, N=5, inputs 10,20,1,0,-1 -> outputs 10,20,31,42,52; oDone one cycle after last oValid.
REQ-036 Order 4, N=6, inputs 1,2,3,4,0,0 -> outputs 1,2,3,4,5,6 (linear extrapolation).
REQ-037 Order 1, N=3, inputs 32767,1,0 -> wrap build: 32767,-32768,-32768; SATURATE_EN build: 32767,32767,32767.
REQ-038 iOrder=6, iStart -> oError=1, oDone pulse, zero oValid; next legal iStart clears oError.
REQ-039 Order 3, N=8, iStart reissued after 4 outputs, then order 0 N=2 inputs -7,7 -> outputs -7,7, single oDone only for second subframe.
REQ-040 Order 2, N=1, input 100 -> single output 100, oDone, second warm-up never awaited; iReset mid-S_RESIDUAL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fixed_decoder_if.sv
// Bus between the residual-decoder side and fixed_decoder.
// The master drives the subframe control and residuals; the slave returns reconstructed PCM.
interface fixed_decoder_if;
    logic               iStart;
    logic [2:0]         iOrder;
    logic [15:0]        iNSamples;
    logic signed [15:0] iSample;
    logic               iValid;
    logic signed [15:0] oSample;
    logic               oValid;
    logic               oDone;
    logic               oError;

    modport master (
        output iStart, iOrder, iNSamples, iSample, iValid,
        input  oSample, oValid, oDone, oError
    );

    modport slave (
        input  iStart, iOrder, iNSamples, iSample, iValid,
        output oSample, oValid, oDone, oError
    );
endinterface

// File: rtl/fixed_decoder.sv
// FLAC-style fixed-predictor subframe decoder: passes warm-up samples through, then adds residuals
// to an order 0..4 polynomial prediction. FIXED_DECODER_SATURATE_EN clamps results instead of wrapping.
module fixed_decoder (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iEnable,
    fixed_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WARMUP   = 2'd1,
        S_RESIDUAL = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [2:0]         order_r, order_s;
    logic [15:0]        n_r, n_s;
    logic [15:0]        cnt_r, cnt_s;
    logic signed [15:0] s1_r, s2_r, s3_r, s4_r;
    logic signed [15:0] s1_s, s2_s, s3_s, s4_s;
    logic signed [15:0] sample_r, sample_s;
    logic               valid_r, valid_s;
    logic               done_r, done_s;
    logic               error_r, error_s;
    logic [15:0]        cnt_inc_s;
    logic signed [20:0] sum_s;
    logic signed [15:0] result_s;
    logic               illegal_s;

    function automatic logic signed [20:0] sext(input logic signed [15:0] v);
        return {{5{v[15]}}, v};
    endfunction

    // Worst case |4s1-6s2+4s3-s4| + |residual| stays below 2^20, so 21 bits never overflow.
    function automatic logic signed [20:0] predict(
        input logic [2:0]         order,
        input logic signed [15:0] s1,
        input logic signed [15:0] s2,
        input logic signed [15:0] s3,
        input logic signed [15:0] s4
    );
        logic signed [20:0] p;
        case (order)
            3'd1:    p = sext(s1);
            3'd2:    p = sext(s1) * 21'sd2 - sext(s2);
            3'd3:    p = sext(s1) * 21'sd3 - sext(s2) * 21'sd3 + sext(s3);
            3'd4:    p = sext(s1) * 21'sd4 - sext(s2) * 21'sd6 + sext(s3) * 21'sd4 - sext(s4);
            default: p = 21'sd0;
        endcase
        return p;
    endfunction

    function automatic logic signed [15:0] to_pcm(input logic signed [20:0] v);
        logic signed [15:0] r;
`ifdef FIXED_DECODER_SATURATE_EN
        if (v > 21'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -21'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
`else
        r = v[15:0];
`endif
        return r;
    endfunction

    assign cnt_inc_s = cnt_r + 16'd1;
    assign sum_s     = sext(bus.iSample) + predict(order_r, s1_r, s2_r, s3_r, s4_r);
    assign result_s  = to_pcm(sum_s);
    assign illegal_s = (bus.iOrder > 3'd4);

    // Next-state and next-output logic; everything holds while iEnable is low.
    always_comb begin
        state_s  = state_r;
        order_s  = order_r;
        n_s      = n_r;
        cnt_s    = cnt_r;
        s1_s     = s1_r;
        s2_s     = s2_r;
        s3_s     = s3_r;
        s4_s     = s4_r;
        sample_s = sample_r;
        valid_s  = valid_r;
        done_s   = done_r;
        error_s  = error_r;
        if (iEnable) begin
            valid_s = 1'b0;
            done_s  = 1'b0;
            if (bus.iStart) begin
                order_s = bus.iOrder;
                n_s     = bus.iNSamples;
                cnt_s   = 16'd0;
                s1_s    = 16'sd0;
                s2_s    = 16'sd0;
                s3_s    = 16'sd0;
                s4_s    = 16'sd0;
                error_s = illegal_s;
                if (illegal_s || (bus.iNSamples == 16'd0)) begin
                    state_s = S_DONE;
                end else if (bus.iOrder != 3'd0) begin
                    state_s = S_WARMUP;
                end else begin
                    state_s = S_RESIDUAL;
                end
            end else begin
                case (state_r)
                    S_WARMUP, S_RESIDUAL: begin
                        if (bus.iValid) begin
                            sample_s = (state_r == S_WARMUP) ? bus.iSample : result_s;
                            valid_s  = 1'b1;
                            s1_s     = sample_s;
                            s2_s     = s1_r;
                            s3_s     = s2_r;
                            s4_s     = s3_r;
                            cnt_s    = cnt_inc_s;
                            // Block size is checked first so N < order ends inside warm-up.
                            if (cnt_inc_s == n_r) begin
                                state_s = S_DONE;
                            end else if (cnt_inc_s == {13'd0, order_r}) begin
                                state_s = S_RESIDUAL;
                            end else begin
                                state_s = state_r;
                            end
                        end else begin
                            state_s = state_r;
                        end
                    end
                    S_DONE: begin
                        done_s  = 1'b1;
                        state_s = S_IDLE;
                    end
                    S_IDLE:  state_s = S_IDLE;
                    default: state_s = S_IDLE;
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, history and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r  <= S_IDLE;
            order_r  <= 3'd0;
            n_r      <= 16'd0;
            cnt_r    <= 16'd0;
            s1_r     <= 16'sd0;
            s2_r     <= 16'sd0;
            s3_r     <= 16'sd0;
            s4_r     <= 16'sd0;
            sample_r <= 16'sd0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            order_r  <= order_s;
            n_r      <= n_s;
            cnt_r    <= cnt_s;
            s1_r     <= s1_s;
            s2_r     <= s2_s;
            s3_r     <= s3_s;
            s4_r     <= s4_s;
            sample_r <= sample_s;
            valid_r  <= valid_s;
            done_r   <= done_s;
            error_r  <= error_s;
        end
    end

    assign bus.oSample = sample_r;
    assign bus.oValid  = valid_r;
    assign bus.oDone   = done_r;
    assign bus.oError  = error_r;
endmodule
